// File: rtl/aes_stream_pkg.sv
// aes_stream_pkg: shared definitions for the AES stream adapter slice.
//   - FSM state encoding (IDLE, FILL, LOAD, BUSY, DRAIN)
//   - word-index width for the 4 x 32-bit big-endian block layout
//   - default core timeout
//   - word get/put helpers (word 0 = bits [127:96], word 3 = bits [31:0])
package aes_stream_pkg;

  localparam int WIDX_W          = 2;
  localparam int TIMEOUT_DEFAULT = 255;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_FILL  = 3'd1;
  localparam logic [2:0] ST_LOAD  = 3'd2;
  localparam logic [2:0] ST_BUSY  = 3'd3;
  localparam logic [2:0] ST_DRAIN = 3'd4;

  // Extract big-endian word idx from a 128-bit block.
  function automatic logic [31:0] get_word(input logic [127:0] blk,
                                           input logic [WIDX_W-1:0] idx);
    logic [31:0] w;
    case (idx)
      2'd0:    w = blk[127:96];
      2'd1:    w = blk[95:64];
      2'd2:    w = blk[63:32];
      2'd3:    w = blk[31:0];
      default: w = 32'h0000_0000;
    endcase
    return w;
  endfunction

  // Return blk with big-endian word idx replaced by word.
  function automatic logic [127:0] put_word(input logic [127:0] blk,
                                            input logic [WIDX_W-1:0] idx,
                                            input logic [31:0] word);
    logic [127:0] r;
    r = blk;
    case (idx)
      2'd0:    r[127:96] = word;
      2'd1:    r[95:64]  = word;
      2'd2:    r[63:32]  = word;
      2'd3:    r[31:0]   = word;
      default: r = blk;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/aes_word_unpacker.sv
// aes_word_unpacker: holds one 128-bit result block and presents it as a
// stream of four big-endian 32-bit words.
// Ports:
//   clk, rst      - clock, asynchronous active-high reset
//   capture       - load text_in, present word 0
//   text_in[127:0]- block to capture
//   advance       - step to the next word (word accepted downstream)
//   out_data[31:0]- currently presented word (registered)
//   last          - the presented word is word 3
module aes_word_unpacker
  import aes_stream_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         capture,
  input  logic [127:0] text_in,
  input  logic         advance,
  output logic [31:0]  out_data,
  output logic         last
);

  logic [127:0]       blk_r;
  logic [WIDX_W-1:0]  idx_r;
  logic [WIDX_W-1:0]  idx_nxt_s;
  logic [31:0]        word_r;

  assign idx_nxt_s = idx_r + 2'd1;

  // Block register, word index and registered output word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blk_r  <= 128'h0;
      idx_r  <= 2'd0;
      word_r <= 32'h0000_0000;
    end else if (capture) begin
      blk_r  <= text_in;
      idx_r  <= 2'd0;
      word_r <= text_in[127:96];
    end else if (advance) begin
      idx_r  <= idx_nxt_s;
      word_r <= get_word(blk_r, idx_nxt_s);
    end else begin
      word_r <= word_r;
    end
  end

  assign out_data = word_r;
  assign last     = (idx_r == 2'd3);

endmodule

// File: rtl/aes_stream_adapter.sv
// aes_stream_adapter: bridges a 32-bit valid/ready plaintext stream and a
// 32-bit valid/ready ciphertext stream to a 128-bit aes_cipher_top style core.
// Ports:
//   clk, rst                  - clock, asynchronous active-high reset
//   key_wr/key_idx/key_word   - key shadow word write (any state)
//   in_valid/in_ready/in_data - plaintext words, big-endian order
//   out_valid/out_ready/out_data - ciphertext words, big-endian order
//   core_ld/core_key/core_text   - core load strobe, key and plaintext block
//   core_done/core_text_out      - core completion and result block
//   err                       - sticky core timeout flag (cleared by reset only)
//   blk_cnt                   - completed block counter (wraps)
module aes_stream_adapter
  import aes_stream_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         key_wr,
  input  logic [1:0]   key_idx,
  input  logic [31:0]  key_word,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [31:0]  in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [31:0]  out_data,
  output logic         core_ld,
  output logic [127:0] core_key,
  output logic [127:0] core_text,
  input  logic         core_done,
  input  logic [127:0] core_text_out,
  output logic         err,
  output logic [15:0]  blk_cnt
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [2:0]        state_r;
  logic [2:0]        state_nxt_s;
  logic [WIDX_W-1:0] wcnt_r;
  logic [127:0]      text_r;
  logic [127:0]      key_shadow_r;
  logic [127:0]      key_shadow_nxt_s;
  logic [127:0]      core_key_r;
  logic              core_ld_r;
  logic              in_ready_r;
  logic              out_valid_r;
  logic              err_r;
  logic [15:0]       blk_cnt_r;
  logic [CNT_W-1:0]  busy_cnt_r;
  logic              in_fire_s;
  logic              out_fire_s;
  logic              capture_s;
  logic              timeout_s;
  logic              last_s;
  logic              load_entry_s;

  assign in_fire_s    = in_valid && in_ready_r;
  assign out_fire_s   = out_valid_r && out_ready;
  assign capture_s    = (state_r == ST_BUSY) && core_done;
  // busy_cnt_r counts cycles since core_ld rose, so this fires on the
  // edge that completes TIMEOUT cycles without a done.
  assign timeout_s    = (state_r == ST_BUSY) && !core_done &&
                        (busy_cnt_r == CNT_W'(TIMEOUT - 1));
  assign load_entry_s = (state_nxt_s == ST_LOAD) && (state_r != ST_LOAD);

  // Key shadow with this cycle's write applied, so a write coinciding
  // with LOAD entry reaches the working copy.
  always_comb begin
    key_shadow_nxt_s = key_shadow_r;
    if (key_wr) begin
      key_shadow_nxt_s = put_word(key_shadow_r, key_idx, key_word);
    end else begin
      key_shadow_nxt_s = key_shadow_r;
    end
  end

  // Next-state logic for the block FSM.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (in_fire_s) begin
          state_nxt_s = (wcnt_r == 2'd3) ? ST_LOAD : ST_FILL;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_FILL: begin
        if (in_fire_s && (wcnt_r == 2'd3)) begin
          state_nxt_s = ST_LOAD;
        end else begin
          state_nxt_s = ST_FILL;
        end
      end
      ST_LOAD: state_nxt_s = ST_BUSY;
      ST_BUSY: begin
        if (core_done) begin
          state_nxt_s = ST_DRAIN;
        end else if (timeout_s) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_BUSY;
        end
      end
      ST_DRAIN: begin
        if (out_fire_s && last_s) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_DRAIN;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // State and handshake outputs, registered from the next state so they
  // line up with the state they describe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      in_ready_r  <= 1'b0;
      core_ld_r   <= 1'b0;
      out_valid_r <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      in_ready_r  <= (state_nxt_s == ST_IDLE) || (state_nxt_s == ST_FILL);
      core_ld_r   <= (state_nxt_s == ST_LOAD);
      out_valid_r <= (state_nxt_s == ST_DRAIN);
    end
  end

  // Input word assembly and key shadow / working key.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wcnt_r       <= 2'd0;
      text_r       <= 128'h0;
      key_shadow_r <= 128'h0;
      core_key_r   <= 128'h0;
    end else begin
      key_shadow_r <= key_shadow_nxt_s;
      if (in_fire_s) begin
        text_r <= put_word(text_r, wcnt_r, in_data);
        wcnt_r <= wcnt_r + 2'd1;
      end
      if (load_entry_s) begin
        core_key_r <= key_shadow_nxt_s;
      end
    end
  end

  // Core timeout counter, sticky error and completed-block counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_cnt_r <= '0;
      err_r      <= 1'b0;
      blk_cnt_r  <= 16'h0000;
    end else begin
      if (load_entry_s) begin
        busy_cnt_r <= '0;
      end else if ((state_r == ST_LOAD) || (state_r == ST_BUSY)) begin
        busy_cnt_r <= busy_cnt_r + CNT_W'(1);
      end
      if (timeout_s) begin
        err_r <= 1'b1;
      end
      if (out_fire_s && last_s) begin
        blk_cnt_r <= blk_cnt_r + 16'd1;
      end
    end
  end

  aes_word_unpacker u_unpacker (
    .clk      (clk),
    .rst      (rst),
    .capture  (capture_s),
    .text_in  (core_text_out),
    .advance  (out_fire_s),
    .out_data (out_data),
    .last     (last_s)
  );

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign core_ld   = core_ld_r;
  assign core_key  = core_key_r;
  assign core_text = text_r;
  assign err       = err_r;
  assign blk_cnt   = blk_cnt_r;

endmodule

// File: tb/tb_aes_stream_adapter.sv
// Bench for aes_stream_adapter with a core stub returning key ^ text,
// done 12 cycles after ld.
module tb_aes_stream_adapter;

  localparam int TO = 40;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         key_wr = 1'b0;
  logic [1:0]   key_idx = 2'd0;
  logic [31:0]  key_word = 32'h0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [31:0]  in_data = 32'h0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [31:0]  out_data;
  logic         core_ld;
  logic [127:0] core_key;
  logic [127:0] core_text;
  logic         core_done;
  logic [127:0] core_text_out;
  logic         err;
  logic [15:0]  blk_cnt;

  int checks = 0;
  int errors = 0;
  logic [15:0] exp_blk = 16'h0;

  // core stub
  logic         stub_en = 1'b1;
  logic         extra_done = 1'b0;
  logic         stub_act, stub_done;
  logic [3:0]   stub_cnt;
  logic [127:0] stub_res;

  always #5 clk = ~clk;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      stub_act <= 1'b0; stub_cnt <= 4'd0; stub_done <= 1'b0; stub_res <= 128'h0;
    end else begin
      stub_done <= 1'b0;
      if (core_ld) begin
        stub_act <= 1'b1; stub_cnt <= 4'd1; stub_res <= core_key ^ core_text;
      end else if (stub_act) begin
        stub_cnt <= stub_cnt + 4'd1;
        if (stub_cnt == 4'd11) begin
          stub_done <= stub_en;
          stub_act  <= 1'b0;
        end
      end
    end
  end

  assign core_done     = stub_done | extra_done;
  assign core_text_out = stub_res;

  aes_stream_adapter #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .key_wr(key_wr), .key_idx(key_idx), .key_word(key_word),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .core_ld(core_ld), .core_key(core_key), .core_text(core_text),
    .core_done(core_done), .core_text_out(core_text_out),
    .err(err), .blk_cnt(blk_cnt)
  );

  typedef struct packed {
    logic [127:0] key;
    logic [127:0] pt;
    logic [127:0] exp;
    logic         toggle;
  } vec_t;

  vec_t vecs [4];

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic write_key(input logic [127:0] k);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      key_wr = 1'b1; key_idx = i[1:0]; key_word = k[127-32*i -: 32];
    end
    @(negedge clk);
    key_wr = 1'b0;
  endtask

  // Present one word at a negedge, hold until accepted; returns at a negedge.
  task automatic send_word(input logic [31:0] w);
    int n;
    n = 0;
    in_valid = 1'b1; in_data = w;
    while (!in_ready && n < 50) begin
      @(negedge clk); n++;
    end
    if (!in_ready) begin
      errors++; checks++;
      $display("FAIL in_ready_wait got=0 exp=1");
    end
    @(negedge clk);
    in_valid = 1'b0;
    key_wr   = 1'b0;
  endtask

  // Feed four words; optionally write key word 3 together with the last beat.
  task automatic feed(input logic [127:0] pt, input logic [127:0] exp_key,
                      input bit wt, input logic [31:0] wt_word);
    for (int i = 0; i < 4; i++) begin
      if (wt && i == 3) begin
        key_wr = 1'b1; key_idx = 2'd3; key_word = wt_word;
      end
      send_word(pt[127-32*i -: 32]);
    end
    check("ld_latency", core_ld, 1'b1);
    check("core_key", core_key, exp_key);
    check("core_text", core_text, pt);
  endtask

  // Collect four output words, checking values, stalls and latencies.
  task automatic collect(input logic [127:0] exp, input bit toggle);
    int idx, n;
    bit prev_done;
    idx = 0; n = 0; prev_done = 1'b0;
    out_ready = 1'b1;
    while (idx < 4 && n < 300) begin
      @(negedge clk); n++;
      if (toggle) out_ready = ~out_ready;
      if (n == 1) check("ld_one_cycle", core_ld, 1'b0);
      if (prev_done) check("done_to_valid", out_valid, 1'b1);
      prev_done = core_done && !out_valid;
      if (out_valid) begin
        check("out_word", out_data, exp[127-32*idx -: 32]);
        if (out_ready) idx++;
      end
    end
    if (idx < 4) begin
      errors++; checks++;
      $display("FAIL collect_timeout got=%0d exp=4", idx);
    end
    @(negedge clk);
    out_ready = 1'b0;
    exp_blk = exp_blk + 16'd1;
    check("valid_drop", out_valid, 1'b0);
    check("ready_after", in_ready, 1'b1);
    check("blk_cnt", blk_cnt, exp_blk);
  endtask

  initial begin
    int n;
    bit saw_valid;
    vecs[0] = '{key: 128'hCAFEBABE_DEADBEEF_DEADBEEF_00000000,
                pt:  128'h9F79A3BF_6656A985_3E1238A1_32CB5A2B,
                exp: 128'h55871901_B8FB176A_E0BF864E_32CB5A2B, toggle: 1'b0};
    vecs[1] = '{key: 128'hCAFEBABE_DEADBEEF_DEADBEEF_00000000,
                pt:  128'h9F79A3BF_6656A985_3E1238A1_32CB5A2B,
                exp: 128'h55871901_B8FB176A_E0BF864E_32CB5A2B, toggle: 1'b1};
    vecs[2] = '{key: 128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF,
                pt:  128'h00000000_12345678_A5A5A5A5_FFFFFFFF,
                exp: 128'hFFFFFFFF_EDCBA987_5A5A5A5A_00000000, toggle: 1'b0};
    vecs[3] = '{key: 128'h00000000_11111111_22222222_33333333,
                pt:  128'h01234567_89ABCDEF_FEDCBA98_76543210,
                exp: 128'h01234567_98BADCFE_DCFE98BA_45670123, toggle: 1'b1};

    // reset state
    #12;
    check("rst_flags", {in_ready, out_valid, core_ld, err}, 4'b0000);
    check("rst_out_data", out_data, 32'h0);
    check("rst_core_key", core_key, 128'h0);
    check("rst_core_text", core_text, 128'h0);
    check("rst_blk_cnt", blk_cnt, 16'h0);
    @(negedge clk);
    rst = 1'b0;
    check("ready_before_edge", in_ready, 1'b0);
    @(negedge clk);
    check("ready_first_edge", in_ready, 1'b1);

    // table-driven blocks
    for (int v = 0; v < 4; v++) begin
      write_key(vecs[v].key);
      feed(vecs[v].pt, vecs[v].key, 1'b0, 32'h0);
      collect(vecs[v].exp, vecs[v].toggle);
    end

    // core_done outside BUSY is ignored
    @(negedge clk);
    extra_done = 1'b1;
    @(negedge clk);
    extra_done = 1'b0;
    check("stray_done_valid", out_valid, 1'b0);
    @(negedge clk);
    check("stray_done_valid2", out_valid, 1'b0);
    check("stray_done_ready", in_ready, 1'b1);

    // key write coinciding with LOAD entry reaches the working key
    feed(vecs[3].pt, 128'h00000000_11111111_22222222_FFFFFFFF, 1'b1, 32'hFFFFFFFF);
    collect(128'h01234567_98BADCFE_DCFE98BA_89ABCDEF, 1'b0);

    // key change during BUSY only affects the next block
    write_key(vecs[0].key);
    feed(vecs[0].pt, vecs[0].key, 1'b0, 32'h0);
    key_wr = 1'b1; key_idx = 2'd0; key_word = 32'h0;
    @(negedge clk);
    key_wr = 1'b0;
    collect(vecs[0].exp, 1'b0);
    feed(vecs[0].pt, 128'h00000000_DEADBEEF_DEADBEEF_00000000, 1'b0, 32'h0);
    collect(128'h9F79A3BF_B8FB176A_E0BF864E_32CB5A2B, 1'b0);

    // timeout: no done from the core
    stub_en = 1'b0;
    feed(vecs[2].pt, 128'h00000000_DEADBEEF_DEADBEEF_00000000, 1'b0, 32'h0);
    n = 0; saw_valid = 1'b0;
    while (!err && n < TO + 20) begin
      @(negedge clk); n++;
      saw_valid |= out_valid;
    end
    check("timeout_cycles", n, TO);
    check("timeout_err", err, 1'b1);
    check("timeout_ready", in_ready, 1'b1);
    check("timeout_no_valid", saw_valid, 1'b0);
    stub_en = 1'b1;

    // err is sticky across a later good block
    feed(vecs[0].pt, 128'h00000000_DEADBEEF_DEADBEEF_00000000, 1'b0, 32'h0);
    collect(128'h9F79A3BF_B8FB176A_E0BF864E_32CB5A2B, 1'b0);
    check("err_sticky", err, 1'b1);

    // reset mid-block aborts it and clears everything
    write_key(vecs[3].key);
    send_word(32'h11111111);
    send_word(32'h22222222);
    rst = 1'b1;
    #1;
    check("abort_flags", {in_ready, out_valid, core_ld, err}, 4'b0000);
    check("abort_out_data", out_data, 32'h0);
    check("abort_core_key", core_key, 128'h0);
    check("abort_core_text", core_text, 128'h0);
    check("abort_blk_cnt", blk_cnt, 16'h0);
    @(negedge clk);
    rst = 1'b0;
    exp_blk = 16'h0;
    @(negedge clk);
    check("abort_ready", in_ready, 1'b1);
    check("abort_no_valid", out_valid, 1'b0);
    // shadow key was cleared, so the result equals the plaintext
    feed(vecs[0].pt, 128'h0, 1'b0, 32'h0);
    collect(vecs[0].pt, 1'b0);

    // blk_cnt wrap
    force dut.blk_cnt_r = 16'hFFFF;
    @(negedge clk);
    release dut.blk_cnt_r;
    @(negedge clk);
    check("blk_preload", blk_cnt, 16'hFFFF);
    exp_blk = 16'hFFFF;
    feed(vecs[2].pt, 128'h0, 1'b0, 32'h0);
    collect(vecs[2].pt, 1'b1);
    check("blk_wrap", blk_cnt, 16'h0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
